// File: rtl/decimal_to_ieee754.sv
// Converts a signed 32-bit integer to IEEE-754 binary32 with round-to-nearest-even.
// Latency: 1 cycle, registered output, one conversion per cycle.
// Backpressure: none; every in_valid produces exactly one out_valid pulse.
module decimal_to_ieee754 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] decimal,
    output logic        out_valid,
    output logic [31:0] ieee754
);

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  p;
    logic [31:0] norm;
    logic [22:0] frac_trunc;
    logic        lsb;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_rnd;
    logic [7:0]  exp_base;
    logic [7:0]  exp_final;
    logic [22:0] frac_final;
    logic [31:0] result;

    assign sign = decimal[31];
    // Negating -2^31 wraps back to 32'h80000000, which is the correct magnitude.
    assign mag  = sign ? (~decimal + 32'd1) : decimal;

    always_comb begin
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                p = i[4:0];
            end
        end
    end

    // Leading one moved to bit 31; for small values the dropped bits are all zero.
    assign norm       = mag << (5'd31 - p);
    assign frac_trunc = norm[30:8];
    assign lsb        = norm[8];
    assign guard      = norm[7];
    assign sticky     = |norm[6:0];
    assign round_up   = guard & (sticky | lsb);
    assign frac_rnd   = {1'b0, frac_trunc} + {23'd0, round_up};
    assign exp_base   = 8'd127 + {3'd0, p};

    always_comb begin
        exp_final  = exp_base;
        frac_final = frac_rnd[22:0];
        if (frac_rnd[23]) begin
            exp_final  = exp_base + 8'd1;
            frac_final = 23'd0;
        end
    end

    assign result = (mag == 32'd0) ? 32'h0000_0000 : {sign, exp_final, frac_final};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ieee754   <= 32'h0000_0000;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ieee754 <= result;
            end
        end
    end

endmodule

// File: tb/tb_decimal_to_ieee754.sv
// Directed-vector bench for decimal_to_ieee754 with hand-computed binary32 results.
module tb_decimal_to_ieee754;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] decimal;
    logic        out_valid;
    logic [31:0] ieee754;

    int checks;
    int failures;

    decimal_to_ieee754 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .decimal   (decimal),
        .out_valid (out_valid),
        .ieee754   (ieee754)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one input, step one edge, then confirm the result landed that cycle.
    task automatic convert(input string tag, input logic [31:0] val, input logic [31:0] exp);
        in_valid = 1'b1;
        decimal  = val;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check(tag, ieee754, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        decimal  = 32'd0;
        #1;
        check("reset_val", ieee754, 32'h0);
        check("reset_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        convert("pre_rst_5", 32'd5, 32'h40A0_0000);
        // Asynchronous reset mid-cycle, with a conversion pending on the input.
        decimal  = 32'd7;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_val", ieee754, 32'h0);
        check("async_rst_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_val", ieee754, 32'h0);
        check("rst_hold_vld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle_vld", {31'd0, out_valid}, 32'd0);
        check("post_rst_idle_val", ieee754, 32'h0);

        convert("zero", 32'd0, 32'h0000_0000);

        convert("one",  32'd1,  32'h3F80_0000);
        convert("two",  32'd2,  32'h4000_0000);
        convert("three", 32'd3, 32'h4040_0000);
        convert("four", 32'd4,  32'h4080_0000);
        convert("ten",  32'd10, 32'h4120_0000);

        convert("neg1",  32'hFFFF_FFFF, 32'hBF80_0000);
        convert("neg2",  32'hFFFF_FFFE, 32'hC000_0000);
        convert("neg3",  32'hFFFF_FFFD, 32'hC040_0000);
        convert("neg10", 32'hFFFF_FFF6, 32'hC120_0000);

        convert("v1234",   32'd1234,   32'h449A_4000);
        convert("v100000", 32'd100000, 32'h47C3_5000);

        convert("tie_even_down", 32'd16777217, 32'h4B80_0000);
        convert("tie_odd_up",    32'd16777219, 32'h4B80_0002);
        convert("sticky_up",     32'd33554435, 32'h4C00_0001);

        convert("max_pos", 32'h7FFF_FFFF, 32'h4F00_0000);
        convert("min_neg", 32'h8000_0000, 32'hCF00_0000);

        in_valid = 1'b0;
        decimal  = 32'd1;
        @(posedge clk);
        #1;
        check("idle_vld", {31'd0, out_valid}, 32'd0);
        check("idle_hold", ieee754, 32'hCF00_0000);
        @(posedge clk);
        #1;
        check("idle_hold2", ieee754, 32'hCF00_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
